fmul_norm_round: RTL

- Downstream consumer of the multiplier's final carry-propagate adder stage (25-bit significand product).
- Takes the raw product, the pre-summed exponent and the result sign.
- Normalizes, applies round-to-nearest-even, adjusts the exponent, and detects overflow/underflow.
- Two-stage valid/ready pipeline that presents a packed sign/exponent/fraction result to the FPU writeback.

---
 rtl/fpu_pkg.sv | 12 +
 rtl/rne_round.sv | 16 +
 rtl/fmul_norm_round.sv | 105 ++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU format defaults, status-flag bit positions and exponent limits.
package fpu_pkg;
  localparam int EW_DEF = 8;
  localparam int FRAC_W_DEF = 16;
  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INEXACT = 2;
  localparam int EXP_MAX = (1 << EW_DEF) - 1;
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction
endpackage

// File: rtl/rne_round.sv
// rne_round: round-to-nearest-even increment of a truncated fraction; shared by mul and add paths.
module rne_round #(
  parameter int FRAC_W = 16
) (
  input  logic [FRAC_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o,
  output logic              inexact_o
);
  logic inc;
  assign inc = guard_i & (sticky_i | mant_i[0]);
  assign {carry_o, frac_o} = {1'b0, mant_i} + {{FRAC_W{1'b0}}, inc};
  assign inexact_o = guard_i | sticky_i;
endmodule

// File: rtl/fmul_norm_round.sv
// fmul_norm_round: normalize, RNE-round and classify a 25-bit significand product in a 2-stage valid/ready pipe.
module fmul_norm_round
  import fpu_pkg::*;
#(
  parameter int EW     = EW_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                IN_SIGN,
  input  logic signed [EW+1:0] IN_EXP,
  input  logic [24:0]         IN_PROD,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_SIGN,
  output logic [EW-1:0]       OUT_EXP,
  output logic [FRAC_W-1:0]   OUT_FRAC,
  output logic                OUT_OVF,
  output logic                OUT_UNF,
  output logic                OUT_INEXACT
);
  localparam int EXP_TOP = exp_max(EW);
  logic                 s1_valid_q, s1_sign_q, s1_zero_q, s1_sub_q, s1_guard_q, s1_sticky_q;
  logic signed [EW+1:0] s1_e_q, s1_e_d;
  logic [FRAC_W-1:0]    s1_mant_q, s1_mant_d;
  logic                 s1_guard_d, s1_sticky_d;
  logic [22:0]          norm;
  logic                 s2_valid_q, s2_sign_q, s2_ready;
  logic [EW-1:0]        s2_exp_q, s2_exp_d;
  logic [FRAC_W-1:0]    s2_frac_q, s2_frac_d, frac;
  logic [2:0]           s2_flags_q, s2_flags_d;
  logic                 carry, inexact, unf, ovf;
  logic signed [EW+1:0] e2;
  assign s2_ready = !s2_valid_q || OUT_READY;
  assign IN_READY = !s1_valid_q || s2_ready;
  // Hidden bit is dropped here; a product >= 2 shifts right and its lost LSB feeds sticky.
  assign norm        = IN_PROD[24] ? IN_PROD[23:1] : IN_PROD[22:0];
  assign s1_e_d      = IN_EXP + $signed({{(EW+1){1'b0}}, IN_PROD[24]});
  assign s1_mant_d   = norm[22 -: FRAC_W];
  assign s1_guard_d  = norm[22-FRAC_W];
  assign s1_sticky_d = (|norm[21-FRAC_W:0]) | (IN_PROD[24] & IN_PROD[0]);
  rne_round #(.FRAC_W(FRAC_W)) u_rnd (
    .mant_i   (s1_mant_q),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .frac_o   (frac),
    .carry_o  (carry),
    .inexact_o(inexact)
  );
  assign e2 = s1_e_q + $signed({{(EW+1){1'b0}}, carry});
  always_comb begin
    unf = !s1_zero_q && (s1_sub_q || e2 < 1);
    ovf = !s1_zero_q && !unf && e2 >= EXP_TOP;
    s2_exp_d  = (s1_zero_q || unf) ? '0 : ovf ? '1 : e2[EW-1:0];
    s2_frac_d = (s1_zero_q || unf || ovf) ? '0 : frac;
    s2_flags_d = '0;
    s2_flags_d[FLAG_OVF]     = ovf;
    s2_flags_d[FLAG_UNF]     = unf;
    s2_flags_d[FLAG_INEXACT] = !s1_zero_q && (unf || ovf || inexact);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_e_q      <= '0;
      s1_mant_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_flags_q  <= '0;
    end else begin
      if (IN_READY) s1_valid_q <= IN_VALID;
      if (IN_VALID && IN_READY) begin
        s1_sign_q   <= IN_SIGN;
        s1_zero_q   <= IN_PROD == '0;
        s1_sub_q    <= IN_PROD[24:23] == 2'b00 && IN_PROD != '0;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
        s1_e_q      <= s1_e_d;
        s1_mant_q   <= s1_mant_d;
      end
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_ready) begin
        s2_sign_q  <= s1_sign_q;
        s2_exp_q   <= s2_exp_d;
        s2_frac_q  <= s2_frac_d;
        s2_flags_q <= s2_flags_d;
      end
    end
  end
  assign OUT_VALID   = s2_valid_q;
  assign OUT_SIGN    = s2_sign_q;
  assign OUT_EXP     = s2_exp_q;
  assign OUT_FRAC    = s2_frac_q;
  assign OUT_OVF     = s2_flags_q[FLAG_OVF];
  assign OUT_UNF     = s2_flags_q[FLAG_UNF];
  assign OUT_INEXACT = s2_flags_q[FLAG_INEXACT];
endmodule
